rggen_irq_sequencer: RTL and testbench
======================================

# rggen_irq_sequencer

Interrupt sequencer that sits in front of a bank of clear-on-write status bit fields (W0C/W1C/WC/WOC). It turns raw event inputs into set pulses for the fields. It presents pending, enabled status bits one at a time to an interrupt consumer through a valid/ready handshake, using a round-robin policy. It also holds each granted source in service until an end-of-interrupt strobe.

## Interface
Parameters:
- WIDTH, 8, number of interrupt sources (1..64)
- ID_WIDTH, derived localparam = max(1, $clog2(WIDTH)), width of source index

Ports:
- i_clk  input  1  clock, rising-edge
- i_rst_n  input  1  reset, asynchronous, active-low
- i_event  input  WIDTH  raw event inputs from hardware
- o_set  output  WIDTH  set strobes; drive the status bit fields' i_set
- i_status  input  WIDTH  masked status values from the bit fields (o_value)
- i_enable  input  WIDTH  per-source interrupt enable
- o_irq  output  1  level: any source is pending (i_status & i_enable != 0)
- o_irq_valid  output  1  a source index is offered
- o_irq_id  output  ID_WIDTH  offered/in-service source index
- i_irq_ready  input  1  consumer accepts the offered index
- i_eoi  input  1  end-of-interrupt pulse from the consumer
- o_busy  output  1  a source is in service

## Operation
- pending = i_status & i_enable; o_irq = |pending, combinational.
- Round-robin pointer rr_ptr (ID_WIDTH bits) holds the highest-priority index. The selection is the first set bit of pending, searching upward from rr_ptr with wrap from WIDTH-1 to 0.
- The FSM has three states: IDLE, OFFER and SERVICE.
  - IDLE: if pending != 0, register the selection into id_q and go to OFFER. Otherwise stay.
  - OFFER: o_irq_valid=1 and o_irq_id=id_q, held stable.
    - If i_irq_ready=1, go to SERVICE.
    - Else, if pending[id_q]=0 (software cleared or disabled the source), withdraw: go to IDLE with o_irq_valid low next cycle. rr_ptr is unchanged.
    - If ready and the withdraw condition occur in the same cycle, ready wins and the block goes to SERVICE.
  - SERVICE: o_busy=1 and o_irq_id=id_q.
    - On i_eoi, set rr_ptr = (id_q+1) mod WIDTH, wrapping to 0 when id_q = WIDTH-1, and go to IDLE.
    - Clearing of status[id_q] during SERVICE does not end service.
- i_eoi outside SERVICE is ignored. i_irq_ready outside OFFER is ignored.
- The selection is not re-evaluated during OFFER. A higher-priority source arriving later waits.

## Timing
- Reset values: o_set=0, o_irq_valid=0, o_irq_id=0, o_busy=0, rr_ptr=0, state=IDLE. o_irq follows its inputs combinationally.
- Reset may be asserted mid-OFFER or mid-SERVICE. All state returns to the reset values immediately, with no handshake completion.
- Latency:
  - pending rising at cycle n gives o_irq_valid=1 at n+1.
  - Acceptance at cycle m gives o_busy=1 at m+1.
  - i_eoi at cycle k gives IDLE at k+1, and the earliest next o_irq_valid is at k+2.
- The handshake completes on a rising edge with o_irq_valid & i_irq_ready both high.
- Event capture: an event on i_event reaches o_set in the same cycle with the macro disabled. With edge detection, o_set is combinational from i_event and a one-cycle history register.

## Configuration
- RGGEN_IRQ_SEQUENCER_EDGE_DETECT_EN defined:
  - o_set = i_event & ~event_q, where event_q is i_event registered and reset to 0.
  - A held-high event produces exactly one set strobe.
  - An event already high out of reset strobes in the first cycle.
- Not defined: o_set = i_event (level pass-through), and no history register is instantiated.

## Structure
- Package rggen_irq_pkg contains:
  - typedef enum logic [1:0] {IRQ_IDLE, IRQ_OFFER, IRQ_SERVICE} rggen_irq_state_e
  - function calc_id_width(int width)
- One sub-module, rggen_rr_selector: combinational rotate/find-first. Parameters WIDTH and ID_WIDTH; inputs request and pointer; outputs found and index.

## Test plan
- WIDTH=8, pending=8'b0000_0101, rr_ptr=0 → offer id 0. Ready, then eoi → offer id 2 two cycles after eoi. Ready, then eoi → rr_ptr=3.
- Source 7 pending with rr_ptr=0 and source 1 pending → id 1 first. After eoi, rr_ptr=2 → id 7. After eoi, rr_ptr wraps to 0.
- Offer id 3 with ready low; clear status[3] → o_irq_valid drops next cycle, state IDLE, rr_ptr unchanged. Repeat the clear in the same cycle as ready → SERVICE with id 3.
- Macro enabled: i_event[4] high for 5 cycles → o_set[4] high exactly one cycle. Macro disabled → o_set[4] high for 5 cycles.
- Assert i_rst_n low during SERVICE of id 5 → o_busy, o_irq_valid and o_irq_id are 0 immediately. After release with pending unchanged → offer id 5 at the cycle after the first clock edge.
- i_eoi pulsed in IDLE and in OFFER → no state change and rr_ptr unchanged. i_enable=0 with status set → o_irq=0 and no offer.

Source files
------------

// File: rtl/rggen_irq_pkg.sv
// Shared types and helpers for the rggen interrupt sequencer.
package rggen_irq_pkg;

  typedef enum logic [1:0] {
    IRQ_IDLE,
    IRQ_OFFER,
    IRQ_SERVICE
  } rggen_irq_state_e;

  // A single source still needs one index bit.
  function automatic int calc_id_width(int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/rggen_rr_selector.sv
// Round-robin find-first: the first set request bit at or above pointer, wrapping to 0.
module rggen_rr_selector #(
  parameter int WIDTH    = 8,
  parameter int ID_WIDTH = 3
) (
  input  logic [WIDTH-1:0]    request,
  input  logic [ID_WIDTH-1:0] pointer,
  output logic                found,
  output logic [ID_WIDTH-1:0] index
);

  always_comb begin
    found = 1'b0;
    index = '0;
    for (int k = 0; k < WIDTH; k++) begin
      int idx;
      idx = (int'(pointer) + k) % WIDTH;
      if (!found && request[idx]) begin
        found = 1'b1;
        index = ID_WIDTH'(idx);
      end
    end
  end

endmodule

// File: rtl/rggen_irq_sequencer.sv
// Interrupt sequencer: event-to-set strobes plus a round-robin valid/ready/EOI front end.
// Define RGGEN_IRQ_SEQUENCER_EDGE_DETECT_EN for rising-edge event capture instead of level pass-through.
module rggen_irq_sequencer
  import rggen_irq_pkg::*;
#(
  parameter  int WIDTH    = 8,
  localparam int ID_WIDTH = calc_id_width(WIDTH)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [WIDTH-1:0]    i_event,
  output logic [WIDTH-1:0]    o_set,
  input  logic [WIDTH-1:0]    i_status,
  input  logic [WIDTH-1:0]    i_enable,
  output logic                o_irq,
  output logic                o_irq_valid,
  output logic [ID_WIDTH-1:0] o_irq_id,
  input  logic                i_irq_ready,
  input  logic                i_eoi,
  output logic                o_busy
);

  rggen_irq_state_e    state_q, state_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]    pending;
  logic                sel_found;
  logic [ID_WIDTH-1:0] sel_index;

`ifdef RGGEN_IRQ_SEQUENCER_EDGE_DETECT_EN
  logic [WIDTH-1:0] event_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      event_q <= '0;
    end else begin
      event_q <= i_event;
    end
  end

  assign o_set = i_event & ~event_q;
`else
  assign o_set = i_event;
`endif

  assign pending = i_status & i_enable;
  assign o_irq   = |pending;

  rggen_rr_selector #(
    .WIDTH    (WIDTH),
    .ID_WIDTH (ID_WIDTH)
  ) u_selector (
    .request (pending),
    .pointer (rr_ptr_q),
    .found   (sel_found),
    .index   (sel_index)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IRQ_IDLE;
      id_q     <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IRQ_IDLE: begin
        if (sel_found) begin
          id_d    = sel_index;
          state_d = IRQ_OFFER;
        end
      end
      IRQ_OFFER: begin
        // Acceptance takes precedence over a withdraw seen in the same cycle.
        if (i_irq_ready) begin
          state_d = IRQ_SERVICE;
        end else if (!pending[id_q]) begin
          state_d = IRQ_IDLE;
        end
      end
      IRQ_SERVICE: begin
        if (i_eoi) begin
          rr_ptr_d = (id_q == ID_WIDTH'(WIDTH - 1)) ? '0 : id_q + 1'b1;
          state_d  = IRQ_IDLE;
        end
      end
      default: state_d = IRQ_IDLE;
    endcase
  end

  assign o_irq_valid = (state_q == IRQ_OFFER);
  assign o_busy      = (state_q == IRQ_SERVICE);
  // The index is only meaningful while offered or in service; park it at 0 otherwise.
  assign o_irq_id    = (o_irq_valid || o_busy) ? id_q : '0;

endmodule

// File: tb/tb_rggen_irq_sequencer.sv
// Self-checking bench for rggen_irq_sequencer: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_rggen_irq_sequencer;

  localparam int WIDTH = 8;

  logic             i_clk;
  logic             i_rst_n;
  logic [WIDTH-1:0] i_event;
  logic [WIDTH-1:0] o_set;
  logic [WIDTH-1:0] i_status;
  logic [WIDTH-1:0] i_enable;
  logic             o_irq;
  logic             o_irq_valid;
  logic [2:0]       o_irq_id;
  logic             i_irq_ready;
  logic             i_eoi;
  logic             o_busy;

  rggen_irq_sequencer #(.WIDTH(WIDTH)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_event     (i_event),
    .o_set       (o_set),
    .i_status    (i_status),
    .i_enable    (i_enable),
    .o_irq       (o_irq),
    .o_irq_valid (o_irq_valid),
    .o_irq_id    (o_irq_id),
    .i_irq_ready (i_irq_ready),
    .i_eoi       (i_eoi),
    .o_busy      (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: which source is offered / in service (-1 = none), and the priority start.
  int               m_offer;
  int               m_serve;
  int               m_rr;
  logic [WIDTH-1:0] m_prev_event;
  logic [WIDTH-1:0] pend;
  assign pend = i_status & i_enable;

  function automatic int first_pending(input logic [WIDTH-1:0] p, input int start);
    for (int k = 0; k < WIDTH; k++) begin
      if (p[(start + k) % WIDTH]) return (start + k) % WIDTH;
    end
    return -1;
  endfunction

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_offer      <= -1;
      m_serve      <= -1;
      m_rr         <= 0;
      m_prev_event <= '0;
    end else begin
      m_prev_event <= i_event;
      if (m_serve >= 0) begin
        if (i_eoi) begin
          m_rr    <= (m_serve + 1) % WIDTH;
          m_serve <= -1;
        end
      end else if (m_offer >= 0) begin
        if (i_irq_ready) begin
          m_serve <= m_offer;
          m_offer <= -1;
        end else if (!pend[m_offer]) begin
          m_offer <= -1;
        end
      end else begin
        m_offer <= first_pending(pend, m_rr);
      end
    end
  end

  bit cmp_en = 1'b0;

  always @(negedge i_clk) begin
    if (cmp_en) begin
      int               exp_id;
      logic [WIDTH-1:0] exp_set;
      exp_id = (m_offer >= 0) ? m_offer : ((m_serve >= 0) ? m_serve : 0);
`ifdef RGGEN_IRQ_SEQUENCER_EDGE_DETECT_EN
      exp_set = i_event & ~m_prev_event;
`else
      exp_set = i_event;
`endif
      chk("cyc_irq",   64'(o_irq),       64'(|pend));
      chk("cyc_valid", 64'(o_irq_valid), 64'(m_offer >= 0));
      chk("cyc_busy",  64'(o_busy),      64'(m_serve >= 0));
      chk("cyc_id",    64'(o_irq_id),    64'(exp_id));
      chk("cyc_set",   64'(o_set),       64'(exp_set));
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst_n     = 1'b0;
    i_status    = '0;
    i_enable    = '1;
    i_event     = '0;
    i_irq_ready = 1'b0;
    i_eoi       = 1'b0;
    tick();
    tick();
    i_rst_n = 1'b1;
  endtask

  task automatic expect_offer(input string name, input int id);
    chk({name, "_valid"}, 64'(o_irq_valid), 64'd1);
    chk({name, "_id"},    64'(o_irq_id),    64'(id));
  endtask

  // Accept the current offer, then end its service with an EOI one cycle later.
  task automatic accept_and_eoi();
    i_irq_ready = 1'b1;
    tick();
    i_irq_ready = 1'b0;
    chk("svc_busy", 64'(o_busy), 64'd1);
    i_eoi = 1'b1;
    tick();
    i_eoi = 1'b0;
    chk("eoi_idle", 64'({o_irq_valid, o_busy}), 64'd0);
  endtask

  int set_cnt;

  initial begin
    i_rst_n     = 1'b0;
    i_status    = '0;
    i_enable    = '1;
    i_event     = '0;
    i_irq_ready = 1'b0;
    i_eoi       = 1'b0;
    #1;
    chk("rst_valid", 64'(o_irq_valid), 64'd0);
    chk("rst_busy",  64'(o_busy),      64'd0);
    chk("rst_id",    64'(o_irq_id),    64'd0);
    chk("rst_set",   64'(o_set),       64'd0);
    cmp_en = 1'b1;
    do_reset();

    // Round robin over sources 0 and 2.
    i_status = 8'b0000_0101;
    chk("rr_novalid_same_cycle", 64'(o_irq_valid), 64'd0);
    tick();
    expect_offer("rr_first", 0);
    accept_and_eoi();
    tick();
    expect_offer("rr_second", 2);
    accept_and_eoi();
    tick();
    expect_offer("rr_after3", 0);
    i_status = '0;
    tick();
    chk("withdraw_a", 64'(o_irq_valid), 64'd0);

    // Wrap-around: sources 1 and 7.
    do_reset();
    i_status = 8'h82;
    tick();
    expect_offer("wrap_1", 1);
    accept_and_eoi();
    tick();
    expect_offer("wrap_7", 7);
    accept_and_eoi();
    tick();
    expect_offer("wrap_back", 1);

    // Withdraw, then ready coinciding with the clear.
    do_reset();
    i_status = 8'h08;
    tick();
    expect_offer("wd_offer", 3);
    i_status = '0;
    tick();
    chk("wd_valid", 64'(o_irq_valid), 64'd0);
    chk("wd_busy",  64'(o_busy),      64'd0);
    i_status = 8'h18;
    tick();
    expect_offer("wd_rr_kept", 3);
    i_status    = '0;
    i_irq_ready = 1'b1;
    tick();
    i_irq_ready = 1'b0;
    chk("race_busy", 64'(o_busy),   64'd1);
    chk("race_id",   64'(o_irq_id), 64'd3);
    tick();
    chk("svc_holds_on_clear", 64'(o_busy), 64'd1);
    i_eoi = 1'b1;
    tick();
    i_eoi = 1'b0;

    // Held event.
    set_cnt   = 0;
    i_event[4] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (o_set[4]) set_cnt++;
      tick();
    end
    i_event[4] = 1'b0;
`ifdef RGGEN_IRQ_SEQUENCER_EDGE_DETECT_EN
    chk("event_strobes", 64'(set_cnt), 64'd1);
`else
    chk("event_strobes", 64'(set_cnt), 64'd5);
`endif

    // Reset in the middle of service.
    do_reset();
    i_status = 8'h20;
    tick();
    expect_offer("rst_offer5", 5);
    i_irq_ready = 1'b1;
    tick();
    i_irq_ready = 1'b0;
    chk("rst_pre_busy", 64'(o_busy), 64'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("midrst_busy",  64'(o_busy),      64'd0);
    chk("midrst_valid", 64'(o_irq_valid), 64'd0);
    chk("midrst_id",    64'(o_irq_id),    64'd0);
    tick();
    i_rst_n = 1'b1;
    tick();
    expect_offer("post_rst", 5);

    // EOI outside service is ignored.
    do_reset();
    i_eoi = 1'b1;
    tick();
    i_eoi = 1'b0;
    chk("eoi_idle_valid", 64'(o_irq_valid), 64'd0);
    i_status = 8'h18;
    tick();
    expect_offer("eoi_pre", 3);
    i_eoi = 1'b1;
    tick();
    i_eoi = 1'b0;
    expect_offer("eoi_in_offer", 3);
    accept_and_eoi();
    tick();
    expect_offer("eoi_rr4", 4);

    // Disabled sources never interrupt.
    do_reset();
    i_enable = '0;
    i_status = '1;
    tick();
    tick();
    chk("dis_irq",   64'(o_irq),       64'd0);
    chk("dis_valid", 64'(o_irq_valid), 64'd0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) i_status = i_status ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
      if ($urandom_range(0, 15) == 0) i_enable = WIDTH'($urandom) | WIDTH'($urandom);
      i_irq_ready = ($urandom_range(0, 2) == 0);
      i_eoi       = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) i_event = WIDTH'($urandom);
      i_rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end
    i_rst_n = 1'b1;
    tick();

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
